// File: rtl/lcd_hd44780_sink.sv
// Responder end of a 4-bit HD44780-style character-LCD bus. Decodes
// E-strobed nibbles into commands/data writes, keeps a 2x16 screen shadow,
// and answers busy-flag/address and data reads.
module lcd_hd44780_sink #(
  parameter int unsigned SYNC_STAGES = 2,      // must be >= 2
  parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
  input  logic         CCLK,
  input  logic         RSTn,
  input  logic         LCDE,
  input  logic         LCDRS,
  input  logic         LCDRW,
  input  logic [3:0]   LCDDAT,
  output logic [3:0]   rd_dat,
  output logic         rd_oe,
  output logic [255:0] scr_data,
  output logic         disp_on,
  output logic         byte_valid,
  output logic [7:0]   last_byte,
  output logic         last_rs,
  output logic         busy,
  output logic         overrun
);

  // One sample of the incoming bus; all four inputs travel together.
  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [3:0] dat;
  } bus_t;

  // Nibble phase: INIT8 = 8-bit init mode, HI/LO = expecting high/low nibble.
  typedef enum logic [1:0] {INIT8, HI, LO} phase_e;

  bus_t                   bus_in;
  bus_t [SYNC_STAGES-1:0] sync_pipe;
  bus_t                   bus_s;
  logic                   e_q;
  logic                   strobe;

  phase_e            phase, phase_nxt;
  logic [6:0]        ac, ac_nxt;
  logic              id, id_nxt;
  logic              disp_nxt;
  logic [31:0][7:0]  cells, cells_nxt;   // cell i lives at cells[31-i] == cells[~i]
  logic              busy_nxt;
  logic [4:0]        clr_idx, clr_nxt;
  logic              ovr_nxt;
  logic              bv_nxt;
  logic [7:0]        lb_nxt;
  logic              lrs_nxt;
  logic [3:0]        hi_nib, hi_nxt;

  logic              do_dec;
  logic              dec_rs;
  logic [7:0]        dec_byte;
  logic [5:0]        cur_map;            // {visible, cell index} for the address in ac
  logic [7:0]        rd_cell;
  logic [3:0]        rd_nib;

  // DDRAM address -> {visible, cell}; line 1 is 0x00-0x0F, line 2 is 0x40-0x4F.
  function automatic logic [5:0] ddram_cell(input logic [6:0] a);
    logic [5:0] r;
    r = 6'b0;
    if (a[6:4] == 3'b000)      r = {1'b1, 1'b0, a[3:0]};
    else if (a[6:4] == 3'b100) r = {1'b1, 1'b1, a[3:0]};
    return r;
  endfunction

  // Address counter step; the two 40-byte lines form one ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    return r;
  endfunction

  always_comb begin
    bus_in.e   = LCDE;
    bus_in.rs  = LCDRS;
    bus_in.rw  = LCDRW;
    bus_in.dat = LCDDAT;
  end

  assign bus_s    = sync_pipe[SYNC_STAGES-1];
  assign strobe   = e_q & ~bus_s.e;
  assign scr_data = cells;
  assign cur_map  = ddram_cell(ac);
  assign rd_cell  = cur_map[5] ? cells[~cur_map[4:0]] : BLANK_CHAR;

  // Input synchroniser plus the delayed synced E used for falling-edge detect.
  always_ff @(posedge CCLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_pipe <= '0;
      e_q       <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus_in};
      e_q       <= bus_s.e;
    end
  end

  // Read path: status or cell nibble, chosen by the current phase.
  always_comb begin
    rd_oe  = bus_s.e & bus_s.rw;
    rd_nib = 4'h0;
    if (bus_s.rs) rd_nib = (phase == LO) ? rd_cell[3:0] : rd_cell[7:4];
    else          rd_nib = (phase == LO) ? ac[3:0] : {busy, ac[6:4]};
    rd_dat = rd_oe ? rd_nib : 4'h0;
  end

  // Next-state: phase advance, clear sequencing, command and data decode.
  always_comb begin
    phase_nxt = phase;
    ac_nxt    = ac;
    id_nxt    = id;
    disp_nxt  = disp_on;
    cells_nxt = cells;
    busy_nxt  = busy;
    clr_nxt   = clr_idx;
    ovr_nxt   = overrun;
    bv_nxt    = 1'b0;
    lb_nxt    = last_byte;
    lrs_nxt   = last_rs;
    hi_nxt    = hi_nib;
    do_dec    = 1'b0;
    dec_rs    = 1'b0;
    dec_byte  = 8'h00;

    if (busy) begin
      // Clear in progress: one cell per cycle, strobes are dropped.
      cells_nxt[~clr_idx] = BLANK_CHAR;
      clr_nxt = clr_idx + 5'd1;
      if (clr_idx == 5'd31) begin
        busy_nxt = 1'b0;
        ac_nxt   = 7'h00;
        id_nxt   = 1'b1;
      end
      if (strobe) ovr_nxt = 1'b1;
    end else if (strobe) begin
      if (bus_s.rw) begin
        case (phase)
          HI: phase_nxt = LO;
          LO: begin
            phase_nxt = HI;
            if (bus_s.rs) ac_nxt = ac_step(ac, id);
          end
          default: ;  // reads are ignored in 8-bit init mode
        endcase
      end else begin
        case (phase)
          INIT8: begin
            if (bus_s.dat == 4'h2) phase_nxt = HI;
            else begin
              do_dec   = 1'b1;
              dec_byte = {bus_s.dat, 4'h0};
            end
          end
          HI: begin
            hi_nxt    = bus_s.dat;
            phase_nxt = LO;
          end
          LO: begin
            do_dec    = 1'b1;
            dec_rs    = bus_s.rs;
            dec_byte  = {hi_nib, bus_s.dat};
            phase_nxt = HI;
            bv_nxt    = 1'b1;
            lb_nxt    = dec_byte;
            lrs_nxt   = bus_s.rs;
          end
          default: phase_nxt = INIT8;
        endcase
      end
    end

    if (do_dec) begin
      if (dec_rs) begin
        if (cur_map[5]) cells_nxt[~cur_map[4:0]] = dec_byte;
        ac_nxt = ac_step(ac, id);
      end else if (dec_byte[7]) begin
        ac_nxt = dec_byte[6:0];
      end else if (dec_byte[6]) begin
        // CGRAM address: accepted, no shadow effect
      end else if (dec_byte[5]) begin
        if (dec_byte[4]) phase_nxt = INIT8;
      end else if (dec_byte[4]) begin
        // cursor/display shift: accepted, no shadow effect
      end else if (dec_byte[3]) begin
        disp_nxt = dec_byte[2];
      end else if (dec_byte[2]) begin
        id_nxt = dec_byte[1];
      end else if (dec_byte[1]) begin
        ac_nxt = 7'h00;
      end else if (dec_byte[0]) begin
        busy_nxt = 1'b1;
        clr_nxt  = 5'd0;
      end
    end
  end

  // Nibble-phase state register.
  always_ff @(posedge CCLK or negedge RSTn) begin
    if (!RSTn) phase <= INIT8;
    else       phase <= phase_nxt;
  end

  // Datapath registers: screen shadow, address counter, flags.
  always_ff @(posedge CCLK or negedge RSTn) begin
    if (!RSTn) begin
      ac         <= 7'h00;
      id         <= 1'b1;
      disp_on    <= 1'b0;
      cells      <= {32{BLANK_CHAR}};
      busy       <= 1'b0;
      clr_idx    <= 5'd0;
      overrun    <= 1'b0;
      byte_valid <= 1'b0;
      last_byte  <= 8'h00;
      last_rs    <= 1'b0;
      hi_nib     <= 4'h0;
    end else begin
      ac         <= ac_nxt;
      id         <= id_nxt;
      disp_on    <= disp_nxt;
      cells      <= cells_nxt;
      busy       <= busy_nxt;
      clr_idx    <= clr_nxt;
      overrun    <= ovr_nxt;
      byte_valid <= bv_nxt;
      last_byte  <= lb_nxt;
      last_rs    <= lrs_nxt;
      hi_nib     <= hi_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_sink.sv
// Bench for lcd_hd44780_sink: init table, hand-written corner sequences,
// then random byte traffic checked against a DDRAM-ring screen model.
module tb_lcd_hd44780_sink;
  logic         CCLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         LCDE = 1'b0, LCDRS = 1'b0, LCDRW = 1'b0;
  logic [3:0]   LCDDAT = 4'h0;
  logic [3:0]   rd_dat;
  logic         rd_oe;
  logic [255:0] scr_data;
  logic         disp_on, byte_valid, last_rs, busy, overrun;
  logic [7:0]   last_byte;

  int checks = 0, failures = 0;
  int bv_cnt = 0, bv_base = 0;

  always #5 CCLK = ~CCLK;

  lcd_hd44780_sink dut (
    .CCLK(CCLK), .RSTn(RSTn), .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW),
    .LCDDAT(LCDDAT), .rd_dat(rd_dat), .rd_oe(rd_oe), .scr_data(scr_data),
    .disp_on(disp_on), .byte_valid(byte_valid), .last_byte(last_byte),
    .last_rs(last_rs), .busy(busy), .overrun(overrun)
  );

  always @(posedge CCLK) if (byte_valid === 1'b1) bv_cnt <= bv_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_scr[32];
  int         m_ac;
  bit         m_inc, m_disp, m_lrs;
  int         m_phase;   // 0 = 8-bit init, 1 = expecting high nibble, 2 = expecting low
  logic [3:0] m_hi;
  logic [7:0] m_last;
  int         m_bv;

  function automatic int m_cell(input int a);
    if (a >= 0 && a < 16)  return a;
    if (a >= 64 && a < 80) return a - 48;
    return -1;
  endfunction

  // DDRAM as an 80-entry ring: line1 0..39, line2 64..103.
  function automatic int m_step(input int a, input bit inc);
    int p;
    p = (a < 64) ? a : a - 24;
    p = inc ? (p + 1) % 80 : (p + 79) % 80;
    return (p < 40) ? p : p + 24;
  endfunction

  function automatic logic [255:0] m_vec();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[255-8*i -: 8] = m_scr[i];
    return v;
  endfunction

  function automatic logic [3:0] m_read_exp(input logic rs);
    logic [7:0] v;
    int c;
    if (!rs) v = {1'b0, 7'(m_ac)};
    else begin
      c = m_cell(m_ac);
      v = (c < 0) ? 8'h20 : m_scr[c];
    end
    return (m_phase == 2) ? v[3:0] : v[7:4];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
    m_ac = 0; m_inc = 1; m_disp = 0; m_phase = 0; m_hi = 0;
    m_last = 8'h00; m_lrs = 0; m_bv = 0; bv_base = bv_cnt;
  endtask

  task automatic m_cmd(input logic [7:0] b);
    if (b[7]) m_ac = int'(b[6:0]);
    else if (b[6]) begin end
    else if (b[5]) begin if (b[4]) m_phase = 0; end
    else if (b[4]) begin end
    else if (b[3]) m_disp = b[2];
    else if (b[2]) m_inc = b[1];
    else if (b[1]) m_ac = 0;
    else if (b[0]) begin
      for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
      m_ac = 0; m_inc = 1;
    end
  endtask

  task automatic m_strobe(input logic rs, input logic rw, input logic [3:0] d);
    logic [7:0] b;
    int c;
    if (rw) begin
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) begin
        if (rs) m_ac = m_step(m_ac, m_inc);
        m_phase = 1;
      end
    end else if (m_phase == 0) begin
      if (d == 4'h2) m_phase = 1;
      else m_cmd({d, 4'h0});
    end else if (m_phase == 1) begin
      m_hi = d; m_phase = 2;
    end else begin
      b = {m_hi, d}; m_phase = 1; m_bv++; m_last = b; m_lrs = rs;
      if (rs) begin
        c = m_cell(m_ac);
        if (c >= 0) m_scr[c] = b;
        m_ac = m_step(m_ac, m_inc);
      end else m_cmd(b);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
    logic [3:0] exp_rd;
    int ph0;
    exp_rd = m_read_exp(rs);
    ph0 = m_phase;
    @(posedge CCLK); #2; LCDRS = rs; LCDRW = rw; LCDDAT = d;
    @(posedge CCLK); #2; LCDE = 1'b1;
    repeat (4) @(posedge CCLK);
    #1;
    if (rw && ph0 != 0) begin
      chk("rd_oe", rd_oe, 1);
      chk("rd_dat", rd_dat, exp_rd);
    end
    #1 LCDE = 1'b0;
    m_strobe(rs, rw, d);
    repeat (6) @(posedge CCLK);
    #1;
  endtask

  task automatic wr_byte(input logic rs, input logic [7:0] b);
    nib(rs, 1'b0, b[7:4]);
    nib(rs, 1'b0, b[3:0]);
    if (!rs && b == 8'h01) begin
      repeat (40) @(posedge CCLK);
      #1;
    end
  endtask

  task automatic rd_byte(input logic rs);
    nib(rs, 1'b1, 4'h0);
    nib(rs, 1'b1, 4'h0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/scr"}, scr_data, m_vec());
    chk({tag, "/disp"}, disp_on, m_disp);
    chk({tag, "/last_byte"}, last_byte, m_last);
    chk({tag, "/last_rs"}, last_rs, m_lrs);
    chk({tag, "/bv_count"}, bv_cnt - bv_base, m_bv);
    chk({tag, "/busy"}, busy, 0);
  endtask

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    logic [7:0] last;
    logic       lrs;
    logic       disp;
    int         bv;
    logic [15:0] top;
  } vec_t;

  vec_t tbl[16];
  logic [255:0] blank;

  initial begin
    int busy_cycles;
    blank = {32{8'h20}};
    tbl[0]  = '{1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 0, 16'h2020};
    tbl[1]  = '{1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 0, 16'h2020};
    tbl[2]  = '{1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 0, 16'h2020};
    tbl[3]  = '{1'b0, 4'h2, 8'h00, 1'b0, 1'b0, 0, 16'h2020};
    tbl[4]  = '{1'b0, 4'h2, 8'h00, 1'b0, 1'b0, 0, 16'h2020};
    tbl[5]  = '{1'b0, 4'h8, 8'h28, 1'b0, 1'b0, 1, 16'h2020};
    tbl[6]  = '{1'b0, 4'h0, 8'h28, 1'b0, 1'b0, 1, 16'h2020};
    tbl[7]  = '{1'b0, 4'hC, 8'h0C, 1'b0, 1'b1, 2, 16'h2020};
    tbl[8]  = '{1'b0, 4'h0, 8'h0C, 1'b0, 1'b1, 2, 16'h2020};
    tbl[9]  = '{1'b0, 4'h6, 8'h06, 1'b0, 1'b1, 3, 16'h2020};
    tbl[10] = '{1'b0, 4'h8, 8'h06, 1'b0, 1'b1, 3, 16'h2020};
    tbl[11] = '{1'b0, 4'h0, 8'h80, 1'b0, 1'b1, 4, 16'h2020};
    tbl[12] = '{1'b1, 4'h3, 8'h80, 1'b0, 1'b1, 4, 16'h2020};
    tbl[13] = '{1'b1, 4'h0, 8'h30, 1'b1, 1'b1, 5, 16'h3020};
    tbl[14] = '{1'b1, 4'h3, 8'h30, 1'b1, 1'b1, 5, 16'h3020};
    tbl[15] = '{1'b1, 4'h1, 8'h31, 1'b1, 1'b1, 6, 16'h3031};

    // Reset state
    repeat (3) @(posedge CCLK);
    #2 RSTn = 1'b1;
    m_reset();
    repeat (3) @(posedge CCLK);
    #1;
    chk("rst_scr", scr_data, blank);
    chk("rst_disp", disp_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_oe", rd_oe, 0);
    chk("rst_rd_dat", rd_dat, 0);
    chk("rst_bv", byte_valid, 0);
    chk("rst_last", last_byte, 0);
    chk("rst_ovr", overrun, 0);

    // Init sequence and first characters
    for (int i = 0; i < 16; i++) begin
      nib(tbl[i].rs, 1'b0, tbl[i].nib);
      chk($sformatf("tbl%0d_last", i), last_byte, tbl[i].last);
      chk($sformatf("tbl%0d_lrs", i), last_rs, tbl[i].lrs);
      chk($sformatf("tbl%0d_disp", i), disp_on, tbl[i].disp);
      chk($sformatf("tbl%0d_bv", i), bv_cnt - bv_base, tbl[i].bv);
      chk($sformatf("tbl%0d_top", i), scr_data[255:240], tbl[i].top);
    end

    // Last visible cell, then an off-screen write; check write latency
    wr_byte(1'b0, 8'hCF);
    nib(1'b1, 1'b0, 4'h4);
    @(posedge CCLK); #2; LCDRS = 1'b1; LCDRW = 1'b0; LCDDAT = 4'h1;
    @(posedge CCLK); #2; LCDE = 1'b1;
    repeat (4) @(posedge CCLK);
    #2 LCDE = 1'b0;
    m_strobe(1'b1, 1'b0, 4'h1);
    @(posedge CCLK); #1;
    chk("lat_e1_bv", byte_valid, 0);
    @(posedge CCLK); #1;
    chk("lat_e2_bv", byte_valid, 0);
    chk("lat_e2_cell31", scr_data[7:0], 8'h20);
    @(posedge CCLK); #1;
    chk("lat_e3_bv", byte_valid, 1);
    chk("lat_e3_cell31", scr_data[7:0], 8'h41);
    @(posedge CCLK); #1;
    chk("lat_e4_bv", byte_valid, 0);
    repeat (3) @(posedge CCLK);
    #1;
    check_all("addr");
    wr_byte(1'b1, 8'h42);
    check_all("offscr");
    chk("cell31_kept", scr_data[7:0], 8'h41);
    rd_byte(1'b0);

    // Clear with an overlapping strobe
    chk("pre_clr_ovr", overrun, 0);
    nib(1'b0, 1'b0, 4'h0);
    @(posedge CCLK); #2; LCDRS = 1'b0; LCDRW = 1'b0; LCDDAT = 4'h1;
    @(posedge CCLK); #2; LCDE = 1'b1;
    repeat (4) @(posedge CCLK);
    #2 LCDE = 1'b0;
    m_strobe(1'b0, 1'b0, 4'h1);
    busy_cycles = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge CCLK); #1;
      if (busy === 1'b1) busy_cycles++;
      #1;
      if (c == 5) begin LCDDAT = 4'h3; LCDE = 1'b1; end
      if (c == 8) LCDE = 1'b0;
    end
    #1;
    chk("clr_busy_cycles", busy_cycles, 32);
    chk("clr_overrun", overrun, 1);
    chk("clr_busy_done", busy, 0);
    chk("clr_scr", scr_data, blank);
    wr_byte(1'b1, 8'h4B);
    check_all("post_clr");
    chk("post_clr_cell0", scr_data[255:248], 8'h4B);
    rd_byte(1'b0);

    // Decrement mode wraps below address 0
    wr_byte(1'b0, 8'h04);
    wr_byte(1'b0, 8'h80);
    wr_byte(1'b1, 8'h5A);
    check_all("dec");
    chk("dec_cell0", scr_data[255:248], 8'h5A);
    wr_byte(1'b1, 8'h77);
    check_all("dec_drop");
    rd_byte(1'b0);
    wr_byte(1'b0, 8'h80);
    rd_byte(1'b1);

    // Reset between the two nibbles of a byte
    nib(1'b0, 1'b0, 4'h8);
    @(posedge CCLK); #3 RSTn = 1'b0;
    #1;
    chk("mid_rst_scr", scr_data, blank);
    chk("mid_rst_disp", disp_on, 0);
    chk("mid_rst_last", last_byte, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bv", byte_valid, 0);
    @(posedge CCLK); #2 RSTn = 1'b1;
    m_reset();
    nib(1'b0, 1'b0, 4'h0);
    nib(1'b0, 1'b0, 4'hC);
    nib(1'b0, 1'b0, 4'h2);
    wr_byte(1'b1, 8'h55);
    check_all("post_rst");
    chk("post_rst_cell16", scr_data[127:120], 8'h55);
    chk("post_rst_bv", bv_cnt - bv_base, 1);

    // Random traffic
    wr_byte(1'b0, 8'h0C);
    for (int k = 0; k < 150; k++) begin
      int op, a;
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3: wr_byte(1'b1, 8'($urandom_range(32, 126)));
        4: begin
          a = $urandom_range(0, 79);
          a = (a < 40) ? a : a + 24;
          wr_byte(1'b0, 8'h80 | 8'(a));
        end
        5: wr_byte(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
        6: wr_byte(1'b0, 8'h08 | 8'($urandom_range(0, 7)));
        7: wr_byte(1'b0, 8'h02);
        8: rd_byte(1'b1);
        9: rd_byte(1'b0);
        10: wr_byte(1'b0, 8'h10 | 8'($urandom_range(0, 15)));
        default: begin
          if ($urandom_range(0, 7) == 0) wr_byte(1'b0, 8'h01);
          else wr_byte(1'b0, 8'h40 | 8'($urandom_range(0, 63)));
        end
      endcase
      check_all("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
